tetris_vga_renderer: RTL and testbench
======================================

Name: tetris_vga_renderer

Overview:
- Downstream consumer of the 24 board-row exports from the SRAM/Nios subsystem (24 rows × 10 cells × 3-bit colour code).
- Generates 640x480@60 VGA timing and snapshots the board once per frame during vertical blanking, so a frame never tears.
- Renders the 10×24 playfield as 16×16-pixel cells with a border, for the on-board 8-bit-per-channel VGA DAC.

Parameters:
- PIX_DIV, 2, clk_clk cycles per pixel (50 MHz → 25 MHz pixel enable); legal values ≥1.
- X_OFF, 240, first visible pixel column of the playfield.
- Y_OFF, 48, first visible line of the playfield.
- BORDER, 4, border thickness in pixels, drawn outside the playfield.

Ports:
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset  in  1  asynchronous, active-high reset.
- rows_in  in  720  row r at bits [30r+29:30r], r=0 is the top row; cell c of a row at [3c+2:3c], c=0 is the leftmost cell; code 0 = empty.
- vga_r  out  8  red.
- vga_g  out  8  green.
- vga_b  out  8  blue.
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.
- vga_blank_n  out  1  high in the visible area.
- pix_en  out  1  pixel-enable strobe, for the DAC clock gating.
- frame_tick  out  1  one-clk_clk pulse when the snapshot is taken.

Behaviour:
- Reset state: counters 0, divider 0, shadow board all 0, vga_hs=vga_vs=1, vga_blank_n=0, rgb=0, frame_tick=0, pix_en=0.
- Divider: counts 0..PIX_DIV-1; pix_en=1 on the cycle the count equals PIX_DIV-1. All timing and pipeline registers advance only when pix_en=1.
- Horizontal counter h, 0..799:
  - visible 0..639
  - front porch 640..655
  - sync 656..751
  - back porch 752..799
- Vertical counter v, 0..524, increments when h wraps 799→0:
  - visible 0..479
  - front porch 480..489
  - sync 490..491
  - back porch 492..524
  - wraps 524→0.
- Snapshot: on the pix_en cycle where h=0 and v=480, shadow ← rows_in and frame_tick=1 for exactly that clk_clk cycle. The shadow does not change at any other time; rows_in changes mid-frame have no visible effect until the next snapshot.
- Pipeline stage 1 (classify):
  - in_field = h in [X_OFF, X_OFF+159] and v in [Y_OFF, Y_OFF+383].
  - col = (h-X_OFF)>>4 (4 bits, 0..9); row = (v-Y_OFF)>>4 (5 bits, 0..23).
  - in_border = inside the rectangle expanded by BORDER on every side, but not in_field.
  - Register code = shadow[row][col] (0 when not in_field), plus in_field, in_border, visible, hsync and vsync terms.
- Pipeline stage 2 (palette), output priority:
  1. Not visible → 000000.
  2. in_border → 808080.
  3. in_field with code 0 → 202020.
  4. in_field with code 1..7 → 00FFFF, FFFF00, 8000FF, 00FF00, FF0000, 0000FF, FF8000 respectively.
  5. Otherwise → 000000.
- Latency: rgb, vga_hs, vga_vs and vga_blank_n for counter position (h,v) appear exactly 2 pix_en strobes after the counters hold (h,v). Sync and blank are delayed through the same two stages, so all outputs stay aligned.
- Arithmetic:
  - h is 10 bits, v is 10 bits.
  - Subtractions are only evaluated under in_field, so no underflow reaches the index.
  - Index math is unsigned. row ≤ 23 and col ≤ 9 are guaranteed by the in_field range.
- Reset mid-frame: all registers return to their reset state immediately (async). After release, scanning restarts at h=0, v=0, and the shadow stays blank until the first v=480 snapshot.

Decomposition:
- Shared package tetris_vga_pkg:
  - H/V timing constants (visible, front porch, sync, back porch, total).
  - CELL_PX=16, COLS=10, ROWS=24, CODE_W=3.
  - Palette constant array of 8 × 24-bit entries, plus EMPTY_RGB and BORDER_RGB.
- One sub-module, vga_timing_gen: owns the divider, the h/v counters, raw hsync/vsync/visible, and pix_en.
- The top level keeps the snapshot register, the two pipeline stages and the palette.

Test Plan:
- Reset, then run 2 frames with PIX_DIV=2 → hs low for 96 strobes per line, line period 1600 clk; vs low for lines 490-491; frame period 840000 clk; frame_tick exactly once per frame at v=480, h=0.
- rows_in with row 0 cell 0 = 1 and all others 0 → pixels (240..255, 48..63) = 00FFFF, pixel (256,48) = 202020, pixel (237,48) = 808080, pixel (100,100) = 000000.
- row 23 cell 9 = 7 → pixels (384..399, 416..431) = FF8000; pixel (400,431) = 808080 (border, since BORDER=4).
- Change rows_in at v=200 mid-frame → displayed frame unchanged until after the next frame_tick; the new value is visible in the following frame.
- Alignment check → at the first pix_en with h=0, v=0, vga_blank_n rises exactly 2 strobes later; hs falls 2 strobes after h=656.
- Assert reset_reset at h=300, v=100 → outputs go to reset values within the same cycle; after release, the shadow is blank (the field renders 202020) until the first frame_tick.

Source files
------------

// File: rtl/tetris_vga_renderer_pkg.sv
// Shared constants, stage-1 payload type and palette for the Tetris VGA renderer.
// Timing defaults are standard 640x480@60; the board is 10x24 cells of 3-bit colour codes.
package tetris_vga_pkg;

    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int unsigned CNT_W   = 10;

    localparam int unsigned CELL_PX   = 16;
    localparam int unsigned CELL_LOG2 = $clog2(CELL_PX);
    localparam int unsigned COLS      = 10;
    localparam int unsigned ROWS      = 24;
    localparam int unsigned CODE_W    = 3;
    localparam int unsigned COL_W     = 4;
    localparam int unsigned ROW_IDX_W = 5;
    localparam int unsigned ROW_W     = COLS * CODE_W;
    localparam int unsigned BOARD_W   = ROWS * ROW_W;
    localparam int unsigned BIDX_W    = $clog2(BOARD_W);

    localparam int unsigned RGB_W = 24;
    localparam logic [RGB_W-1:0] BLACK_RGB  = 24'h000000;
    localparam logic [RGB_W-1:0] EMPTY_RGB  = 24'h202020;
    localparam logic [RGB_W-1:0] BORDER_RGB = 24'h808080;

    // Entry 0 is the empty-cell colour so the field lookup needs no special case.
    localparam logic [RGB_W-1:0] PALETTE [0:(1<<CODE_W)-1] = '{
        EMPTY_RGB,
        24'h00FFFF,
        24'hFFFF00,
        24'h8000FF,
        24'h00FF00,
        24'hFF0000,
        24'h0000FF,
        24'hFF8000
    };

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              in_field;
        logic              in_border;
        logic              visible;
        logic              hsync;
        logic              vsync;
    } classify_t;

    localparam classify_t CLASSIFY_RST = '{
        code:      '0,
        in_field:  1'b0,
        in_border: 1'b0,
        visible:   1'b0,
        hsync:     1'b1,
        vsync:     1'b1
    };

    // Bit offset of cell (row, col) inside the flattened board vector.
    function automatic logic [BIDX_W-1:0] cell_base(
        input logic [ROW_IDX_W-1:0] row,
        input logic [COL_W-1:0]     col
    );
        return BIDX_W'(row) * BIDX_W'(ROW_W) + BIDX_W'(col) * BIDX_W'(CODE_W);
    endfunction

endpackage

// File: rtl/tetris_vga_renderer_timing.sv
// VGA raster timing: pixel-enable divider, h/v counters and raw sync/visible decode.
module vga_timing_gen
    import tetris_vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned H_VIS_P  = H_VIS,
    parameter int unsigned H_FP_P   = H_FP,
    parameter int unsigned H_SYNC_P = H_SYNC,
    parameter int unsigned H_BP_P   = H_BP,
    parameter int unsigned V_VIS_P  = V_VIS,
    parameter int unsigned V_FP_P   = V_FP,
    parameter int unsigned V_SYNC_P = V_SYNC,
    parameter int unsigned V_BP_P   = V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             visible_c,
    output logic             hsync_c,
    output logic             vsync_c
);

    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned H_TOT   = H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int unsigned V_TOT   = V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS_P);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS_P);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VIS_P + H_FP_P);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS_P + H_FP_P + H_SYNC_P);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VIS_P + V_FP_P);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS_P + V_FP_P + V_SYNC_P);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    // pix_en_q is precomputed so it is high exactly while div_q == PIX_DIV-1.
    always_comb begin
        div_d    = div_q;
        pix_en_d = 1'b0;
        h_d      = h_q;
        v_d      = v_q;

        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        pix_en_d = (div_d == DIV_LAST);

        if (pix_en_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            h_q      <= h_d;
            v_q      <= v_d;
        end
    end

    assign pix_en    = pix_en_q;
    assign h_cnt     = h_q;
    assign v_cnt     = v_q;
    assign visible_c = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    assign hsync_c   = !((h_q >= HS_BEG) && (h_q < HS_END));
    assign vsync_c   = !((v_q >= VS_BEG) && (v_q < VS_END));

endmodule

// File: rtl/tetris_vga_renderer.sv
// Tetris playfield renderer: per-frame board snapshot in vertical blanking,
// two-stage classify/palette pipeline with sync and blank delayed alongside the colour.
module tetris_vga_renderer
    import tetris_vga_pkg::*;
#(
    parameter int unsigned PIX_DIV    = 2,
    parameter int unsigned X_OFF      = 240,
    parameter int unsigned Y_OFF      = 48,
    parameter int unsigned BORDER     = 4,
    parameter int unsigned CELL_SHIFT = CELL_LOG2,
    parameter int unsigned H_VIS_P    = H_VIS,
    parameter int unsigned H_FP_P     = H_FP,
    parameter int unsigned H_SYNC_P   = H_SYNC,
    parameter int unsigned H_BP_P     = H_BP,
    parameter int unsigned V_VIS_P    = V_VIS,
    parameter int unsigned V_FP_P     = V_FP,
    parameter int unsigned V_SYNC_P   = V_SYNC,
    parameter int unsigned V_BP_P     = V_BP
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [BOARD_W-1:0] rows_in,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               pix_en,
    output logic               frame_tick
);

    // Signed bounds so a border reaching past column/line 0 compares correctly.
    localparam int FX0 = int'(X_OFF);
    localparam int FX1 = FX0 + int'(COLS << CELL_SHIFT) - 1;
    localparam int FY0 = int'(Y_OFF);
    localparam int FY1 = FY0 + int'(ROWS << CELL_SHIFT) - 1;
    localparam int BX0 = FX0 - int'(BORDER);
    localparam int BX1 = FX1 + int'(BORDER);
    localparam int BY0 = FY0 - int'(BORDER);
    localparam int BY1 = FY1 + int'(BORDER);

    localparam logic [CNT_W-1:0] SNAP_V = CNT_W'(V_VIS_P);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             visible_c;
    logic             hsync_c;
    logic             vsync_c;

    vga_timing_gen #(
        .PIX_DIV  (PIX_DIV),
        .H_VIS_P  (H_VIS_P),
        .H_FP_P   (H_FP_P),
        .H_SYNC_P (H_SYNC_P),
        .H_BP_P   (H_BP_P),
        .V_VIS_P  (V_VIS_P),
        .V_FP_P   (V_FP_P),
        .V_SYNC_P (V_SYNC_P),
        .V_BP_P   (V_BP_P)
    ) u_timing (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .pix_en    (pix_en),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .visible_c (visible_c),
        .hsync_c   (hsync_c),
        .vsync_c   (vsync_c)
    );

    logic [BOARD_W-1:0] shadow_q, shadow_d;
    classify_t          s1_q, s1_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               blank_q, blank_d;

    logic                 snapshot_c;
    int                   hx_c;
    int                   vy_c;
    logic                 in_field_c;
    logic                 in_rect_c;
    logic [CNT_W-1:0]     h_off_c;
    logic [CNT_W-1:0]     v_off_c;
    logic [COL_W-1:0]     col_c;
    logic [ROW_IDX_W-1:0] row_c;
    logic [BIDX_W-1:0]    base_c;
    classify_t            cls_c;
    logic [RGB_W-1:0]     pal_c;

    // The board is latched only at the start of vertical blanking.
    assign snapshot_c = pix_en && (h_cnt == '0) && (v_cnt == SNAP_V);

    // Stage 1: locate the pixel on the board and fetch its colour code.
    always_comb begin
        hx_c       = int'(h_cnt);
        vy_c       = int'(v_cnt);
        in_field_c = (hx_c >= FX0) && (hx_c <= FX1) && (vy_c >= FY0) && (vy_c <= FY1);
        in_rect_c  = (hx_c >= BX0) && (hx_c <= BX1) && (vy_c >= BY0) && (vy_c <= BY1);
        h_off_c    = '0;
        v_off_c    = '0;
        if (in_field_c) begin
            h_off_c = h_cnt - CNT_W'(X_OFF);
            v_off_c = v_cnt - CNT_W'(Y_OFF);
        end
        col_c  = COL_W'(h_off_c >> CELL_SHIFT);
        row_c  = ROW_IDX_W'(v_off_c >> CELL_SHIFT);
        base_c = cell_base(row_c, col_c);

        cls_c           = CLASSIFY_RST;
        cls_c.code      = in_field_c ? shadow_q[base_c +: CODE_W] : '0;
        cls_c.in_field  = in_field_c;
        cls_c.in_border = in_rect_c && !in_field_c;
        cls_c.visible   = visible_c;
        cls_c.hsync     = hsync_c;
        cls_c.vsync     = vsync_c;
    end

    // Stage 2 colour priority: blanking, border, field, background.
    always_comb begin
        pal_c = BLACK_RGB;
        if (!s1_q.visible) begin
            pal_c = BLACK_RGB;
        end else if (s1_q.in_border) begin
            pal_c = BORDER_RGB;
        end else if (s1_q.in_field) begin
            pal_c = PALETTE[s1_q.code];
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        s1_d     = s1_q;
        rgb_d    = rgb_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        blank_d  = blank_q;
        if (snapshot_c) begin
            shadow_d = rows_in;
        end
        if (pix_en) begin
            s1_d    = cls_c;
            rgb_d   = pal_c;
            hs_d    = s1_q.hsync;
            vs_d    = s1_q.vsync;
            blank_d = s1_q.visible;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            shadow_q <= '0;
            s1_q     <= CLASSIFY_RST;
            rgb_q    <= BLACK_RGB;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            blank_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            s1_q     <= s1_d;
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            blank_q  <= blank_d;
        end
    end

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_q;
    // Tick marks the capturing cycle itself; it is an AND of registered terms.
    assign frame_tick  = snapshot_c;

endmodule

// File: tb/tb_tetris_vga_renderer.sv
// Directed bench for tetris_vga_renderer on a scaled-down raster (2x2-pixel cells,
// 56x62 pixel frame) so several whole frames fit in a short run.
module tb_tetris_vga_renderer;

    localparam int unsigned HT    = 56;
    localparam int unsigned VT    = 62;
    localparam int unsigned FRAME = HT * VT;

    logic         clk_clk = 1'b0;
    logic         reset_reset;
    logic [719:0] rows_in;
    logic [7:0]   vga_r, vga_g, vga_b;
    logic         vga_hs, vga_vs, vga_blank_n, pix_en, frame_tick;
    logic [23:0]  rgb;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned ecount;
    int unsigned tick_q[$];
    int unsigned hs_lows;
    logic [719:0] pat_a, pat_b;

    tetris_vga_renderer #(
        .PIX_DIV    (2),
        .X_OFF      (8),
        .Y_OFF      (4),
        .BORDER     (2),
        .CELL_SHIFT (1),
        .H_VIS_P    (40),
        .H_FP_P     (4),
        .H_SYNC_P   (6),
        .H_BP_P     (6),
        .V_VIS_P    (56),
        .V_FP_P     (2),
        .V_SYNC_P   (2),
        .V_BP_P     (2)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .rows_in     (rows_in),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .pix_en      (pix_en),
        .frame_tick  (frame_tick)
    );

    assign rgb = {vga_r, vga_g, vga_b};

    always #10 clk_clk = ~clk_clk;

    // Clock edges since reset release; counters hold strobe index ecount>>1.
    always @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) ecount <= 0;
        else             ecount <= ecount + 1;
    end

    always @(negedge clk_clk) begin
        if (frame_tick === 1'b1) tick_q.push_back(ecount);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Edge after which the outputs first show pixel (h,v) of frame f.
    function automatic int unsigned pe(input int unsigned f, input int unsigned v, input int unsigned h);
        return 2 * (f * FRAME + v * HT + h + 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_to(input int unsigned e);
        if (ecount > e) begin
            n_cmp++;
            n_bad++;
            $error("FAIL run_to: edge count %0d already past %0d", ecount, e);
        end
        while (ecount < e) @(negedge clk_clk);
    endtask

    task automatic pix(input string tag, input int unsigned f, input int unsigned v,
                       input int unsigned h, input logic [23:0] exp);
        run_to(pe(f, v, h));
        chk(tag, 32'(rgb), 32'(exp));
    endtask

    initial begin
        pat_a = '0;
        pat_a[2:0]     = 3'd1;
        pat_a[719:717] = 3'd7;
        pat_b = '0;
        pat_b[2:0] = 3'd3;
        for (int c = 0; c < 8; c++) pat_b[600 + 3*c +: 3] = 3'(c);

        rows_in     = pat_a;
        reset_reset = 1'b1;
        repeat (3) @(negedge clk_clk);
        chk("rst_rgb",   32'(rgb), 32'h0);
        chk("rst_hs",    32'(vga_hs), 32'h1);
        chk("rst_vs",    32'(vga_vs), 32'h1);
        chk("rst_blank", 32'(vga_blank_n), 32'h0);
        chk("rst_pixen", 32'(pix_en), 32'h0);
        chk("rst_tick",  32'(frame_tick), 32'h0);
        reset_reset = 1'b0;

        // Alignment: blank rises two strobes after (0,0), hs falls two strobes after sync start.
        run_to(3);
        chk("pixen_on",   32'(pix_en), 32'h1);
        chk("blank_pre",  32'(vga_blank_n), 32'h0);
        run_to(4);
        chk("pixen_off",  32'(pix_en), 32'h0);
        chk("blank_rise", 32'(vga_blank_n), 32'h1);
        run_to(91);
        chk("hs_pre",  32'(vga_hs), 32'h1);
        run_to(92);
        chk("hs_fall", 32'(vga_hs), 32'h0);

        // Full line 10 of frame 0: border and empty field, shadow still blank.
        hs_lows = 0;
        for (int h = 0; h < int'(HT); h++) begin
            logic [23:0] e;
            run_to(pe(0, 10, h));
            e = (h >= 8 && h <= 27) ? 24'h202020 :
                (h >= 6 && h <= 29) ? 24'h808080 : 24'h000000;
            chk("line_rgb",   32'(rgb), 32'(e));
            chk("line_blank", 32'(vga_blank_n), (h < 40) ? 32'h1 : 32'h0);
            chk("line_hs",    32'(vga_hs), (h >= 44 && h <= 49) ? 32'h0 : 32'h1);
            if (vga_hs === 1'b0) hs_lows++;
        end
        chk("hs_width", hs_lows, 32'd6);

        run_to(pe(0, 55, 39));
        chk("blank_last", 32'(vga_blank_n), 32'h1);
        run_to(pe(0, 56, 0));
        chk("blank_vbl", 32'(vga_blank_n), 32'h0);
        run_to(pe(0, 57, 0));
        chk("vs_57", 32'(vga_vs), 32'h1);
        run_to(pe(0, 58, 0));
        chk("vs_58", 32'(vga_vs), 32'h0);
        run_to(pe(0, 59, 55));
        chk("vs_59", 32'(vga_vs), 32'h0);
        run_to(pe(0, 60, 0));
        chk("vs_60", 32'(vga_vs), 32'h1);

        // Frame 1 shows pattern A; rows_in changes to B mid-frame.
        pix("f1_origin",  1, 0,  0, 24'h000000);
        pix("f1_outside", 1, 4,  5, 24'h000000);
        pix("f1_lborder", 1, 4,  6, 24'h808080);
        pix("f1_lborder", 1, 4,  7, 24'h808080);
        pix("f1_c00",     1, 4,  8, 24'h00FFFF);
        pix("f1_c01",     1, 4, 10, 24'h202020);
        pix("f1_c00b",    1, 5,  9, 24'h00FFFF);
        run_to(pe(1, 20, 0));
        rows_in = pat_b;
        pix("f1_hold",     1, 44, 10, 24'h202020);
        pix("f1_r23c9",    1, 50, 26, 24'hFF8000);
        pix("f1_r23c8",    1, 51, 25, 24'h202020);
        pix("f1_r23c9b",   1, 51, 27, 24'hFF8000);
        pix("f1_rborder",  1, 51, 28, 24'h808080);
        pix("f1_bborder",  1, 52, 27, 24'h808080);

        // Frame 2 shows pattern B: full palette on row 20.
        pix("f2_c00",  2,  4,  8, 24'h8000FF);
        pix("f2_code0", 2, 44,  8, 24'h202020);
        pix("f2_code1", 2, 44, 10, 24'h00FFFF);
        pix("f2_code2", 2, 44, 12, 24'hFFFF00);
        pix("f2_code3", 2, 44, 14, 24'h8000FF);
        pix("f2_code4", 2, 44, 16, 24'h00FF00);
        pix("f2_code5", 2, 44, 18, 24'hFF0000);
        pix("f2_code6", 2, 44, 20, 24'h0000FF);
        pix("f2_code7", 2, 44, 22, 24'hFF8000);
        pix("f2_r23c9", 2, 50, 26, 24'h202020);

        // Mid-frame async reset in frame 3.
        pix("f3_border", 3, 10, 28, 24'h808080);
        reset_reset = 1'b1;
        #1;
        chk("mrst_rgb",   32'(rgb), 32'h0);
        chk("mrst_blank", 32'(vga_blank_n), 32'h0);
        chk("mrst_hs",    32'(vga_hs), 32'h1);
        chk("mrst_vs",    32'(vga_vs), 32'h1);
        chk("mrst_pixen", 32'(pix_en), 32'h0);
        chk("mrst_tick",  32'(frame_tick), 32'h0);
        repeat (2) @(negedge clk_clk);
        reset_reset = 1'b0;

        pix("r0_blank00", 0,  4,  8, 24'h202020);
        pix("r0_blank20", 0, 44, 12, 24'h202020);
        pix("r1_c00",     1,  4,  8, 24'h8000FF);
        pix("r1_code1",   1, 44, 10, 24'h00FFFF);

        // One tick per frame at (0,56); none during the reset-truncated frame 3.
        chk("tick_count", tick_q.size(), 32'd4);
        chk("tick_f0", (tick_q.size() > 0) ? tick_q[0] : 0, 32'd6273);
        chk("tick_f1", (tick_q.size() > 1) ? tick_q[1] : 0, 32'd13217);
        chk("tick_f2", (tick_q.size() > 2) ? tick_q[2] : 0, 32'd20161);
        chk("tick_r0", (tick_q.size() > 3) ? tick_q[3] : 0, 32'd6273);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
